upower_multicycle_control: RTL
==============================

Name: upower_multicycle_control

Overview:
- Multi-cycle main control FSM for the uPOWER datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath enables and the 2-bit ALUOp that feeds the ALU control unit. Opcode and XO go from the IR straight to the ALU control unit.
- Stalls on a memory-ready handshake and flags unsupported encodings.

Parameters:
- OPC_LWZ, 6'd32, load-word opcode
- OPC_STW, 6'd36, store-word opcode
- OPC_BC, 6'd16, conditional branch (branch-if-not-equal semantics)
- OPC_B, 6'd18, unconditional branch
- CNT_W, 32, width of the optional retired-instruction counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  permit fetch of the next instruction
- OpCode  in  6  IR[31:26], sampled in DECODE
- XO  in  9  IR extended opcode, sampled in DECODE
- mem_ready  in  1  memory completes current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero is 0 (bne)
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- IorD  out  1  0 PC address, 1 ALUOut address
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  1 = MDR to register file, 0 = ALUOut to register file
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 PC, 1 register A
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 shifted branch offset
- ALUOp  out  2  00 add, 01 sub, 10 decode OpCode/XO
- instr_done  out  1  one-cycle pulse on last cycle of each retired instruction
- illegal_op  out  1  one-cycle pulse on an unsupported encoding
- state  out  4  current state, for debug

Behaviour:
- Reset: async assertion forces state to FETCH and the counter to 0. While rst_n=0, all outputs are 0. Reset mid-instruction abandons it; no partial write is re-issued.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_X=6, EXEC_D=7, ALU_WB=8, BRANCH=9, JUMP=10, ILLEGAL=11. Codes 12-15 go to FETCH next cycle with all outputs 0.
- Outputs are decoded from state. Only mem_ready qualifies strobes, as listed. Unlisted outputs are 0.
- FETCH:
  - run=0: all outputs 0, hold.
  - run=1: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready.
  - Go to DECODE when run and mem_ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state:
  - OPC_LWZ/OPC_STW -> MEM_ADDR
  - opcode 14, 24, 28 -> EXEC_D
  - opcode 31 with XO in {28, 40, 266, 444, 476} -> EXEC_X
  - OPC_BC -> BRANCH
  - OPC_B -> JUMP
  - anything else -> ILLEGAL
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_READ (load) or MEM_WRITE (store); the opcode is re-sampled and is stable because IR is held.
- MEM_READ: MemRead=1, IorD=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, instr_done=1. Go to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until mem_ready; then instr_done=1 and go to FETCH.
- EXEC_X: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALU_WB.
- EXEC_D: ALUSrcA=1, ALUSrcB=10, ALUOp=10. Go to ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0, instr_done=1. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Go to FETCH.
- ILLEGAL: illegal_op=1, no writes, instr_done=0. Go to FETCH.
- Latency with mem_ready tied high:
  - lwz 5 cycles
  - stw, X-form, D-form 4 cycles
  - bc, b 3 cycles
  - illegal 3 cycles
  - each mem_ready-low cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle
- run deasserted mid-instruction: the current instruction completes; the FSM halts in the next FETCH.

Optional Feature:
- INSTR_COUNT_EN defined: adds output instr_count [CNT_W-1:0]. Increments on every instr_done pulse, wraps from all-ones to 0, cleared by reset.
- INSTR_COUNT_EN undefined: port and counter absent. All other behaviour identical.

Test Plan:
- Reset then run=1, mem_ready=1, IR=lwz (op 32): states 0,1,2,3,4 on cycles 1-5. RegWrite=MemtoReg=1 and instr_done=1 only in cycle 5.
- add (op 31, XO 266), mem_ready=1 -> states 0,1,6,8. ALUOp=10 with ALUSrcB=00 in state 6; RegWrite=1 in state 8.
- stw with mem_ready low for 3 cycles in MEM_WRITE -> MemWrite held 4 cycles; instr_done pulses once, on the mem_ready=1 cycle.
- op 31, XO 100 -> ILLEGAL. illegal_op pulses once; RegWrite, MemWrite and PCWrite stay 0; instr_done=0; back in FETCH.
- bc: state 9 shows ALUOp=01, PCWriteCond=1, PCSource=01. b: state 10 shows PCWrite=1, PCSource=10. Each takes 3 cycles.
- rst_n low during MEM_READ -> all outputs 0 immediately; restart from FETCH. With INSTR_COUNT_EN, instr_count=0 after reset and equals 5 after 5 retired ALU_WB instructions.

Source files
------------

// File: rtl/upower_multicycle_control.sv
// upower_multicycle_control: multi-cycle main control FSM for the uPOWER datapath.
// Steps each instruction through fetch, decode, execute, memory and writeback states.
// It drives the datapath enables and the 2-bit ALUOp used by the ALU control unit.
// Memory strobes stall on mem_ready. Unsupported encodings pass through ILLEGAL.
// Optional feature: define INSTR_COUNT_EN to add the retired-instruction counter
// output instr_count.
module upower_multicycle_control #(
  parameter logic [5:0] OPC_LWZ = 6'd32,
  parameter logic [5:0] OPC_STW = 6'd36,
  parameter logic [5:0] OPC_BC  = 6'd16,
  parameter logic [5:0] OPC_B   = 6'd18
`ifdef INSTR_COUNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] OpCode,
  input  logic [8:0] XO,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
`ifdef INSTR_COUNT_EN
  ,
  output logic [CNT_W-1:0] instr_count
`endif
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_X    = 4'd6,
    S_EXEC_D    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ILLEGAL   = 4'd11
  } state_t;

  state_t r_state;
  state_t w_nextState;
  logic   w_xoSupported;
  logic   w_dFormOp;

  // Recognise the supported X-form extended opcodes and the D-form ALU opcodes
  always_comb begin
    w_xoSupported = (XO == 9'd28)  || (XO == 9'd40)  || (XO == 9'd266) ||
                    (XO == 9'd444) || (XO == 9'd476);
    w_dFormOp     = (OpCode == 6'd14) || (OpCode == 6'd24) || (OpCode == 6'd28);
  end

  // State register; reset abandons any instruction in flight and returns to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; memory states hold until mem_ready, FETCH also waits on run
  always_comb begin
    w_nextState = S_FETCH;
    case (r_state)
      S_FETCH: begin
        if (run && mem_ready) begin
          w_nextState = S_DECODE;
        end else begin
          w_nextState = S_FETCH;
        end
      end
      S_DECODE: begin
        if ((OpCode == OPC_LWZ) || (OpCode == OPC_STW)) begin
          w_nextState = S_MEM_ADDR;
        end else if (w_dFormOp) begin
          w_nextState = S_EXEC_D;
        end else if ((OpCode == 6'd31) && w_xoSupported) begin
          w_nextState = S_EXEC_X;
        end else if (OpCode == OPC_BC) begin
          w_nextState = S_BRANCH;
        end else if (OpCode == OPC_B) begin
          w_nextState = S_JUMP;
        end else begin
          w_nextState = S_ILLEGAL;
        end
      end
      S_MEM_ADDR: begin
        if (OpCode == OPC_LWZ) begin
          w_nextState = S_MEM_READ;
        end else begin
          w_nextState = S_MEM_WRITE;
        end
      end
      S_MEM_READ: begin
        if (mem_ready) begin
          w_nextState = S_MEM_WB;
        end else begin
          w_nextState = S_MEM_READ;
        end
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          w_nextState = S_FETCH;
        end else begin
          w_nextState = S_MEM_WRITE;
        end
      end
      S_EXEC_X:  w_nextState = S_ALU_WB;
      S_EXEC_D:  w_nextState = S_ALU_WB;
      S_MEM_WB:  w_nextState = S_FETCH;
      S_ALU_WB:  w_nextState = S_FETCH;
      S_BRANCH:  w_nextState = S_FETCH;
      S_JUMP:    w_nextState = S_FETCH;
      S_ILLEGAL: w_nextState = S_FETCH;
      default:   w_nextState = S_FETCH;
    endcase
  end

  // Output decode from state; mem_ready qualifies the strobes, and reset forces everything low
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          if (run) begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
          end
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_X: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b00;
          ALUOp   = 2'b10;
        end
        S_EXEC_D: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b10;
        end
        S_ALU_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        S_ILLEGAL: begin
          illegal_op = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign state = r_state;

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] r_instrCount;

  // Retired-instruction counter; wraps naturally from all-ones to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instrCount <= '0;
    end else if (instr_done) begin
      r_instrCount <= r_instrCount + CNT_W'(1);
    end
  end

  assign instr_count = r_instrCount;
`endif

endmodule
